// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer and the
// decoder logic that decides whether an issued instruction is a mult or a div.
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 40;
  localparam int MULT_EXC_CODE      = 4;
  localparam int DIV_EXC_CODE       = 5;

  localparam logic [4:0] OPC_ALU    = 5'b00000;
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  function automatic logic is_multdiv_op(input logic [4:0] opcode,
                                         input logic [4:0] aluop);
    return (opcode == OPC_ALU) && ((aluop == ALUOP_MULT) || (aluop == ALUOP_DIV));
  endfunction

  function automatic logic is_div_op(input logic [4:0] opcode,
                                     input logic [4:0] aluop);
    return (opcode == OPC_ALU) && (aluop == ALUOP_DIV);
  endfunction

endpackage

// File: rtl/multdiv_sequencer.sv
// Drives the shared iterative mult/div unit: captures an issue, pulses start,
// stalls the pipeline until ready or timeout, then strobes the result for one cycle.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = multdiv_sequencer_pkg::TIMEOUT_CYCLES_DEF,
  parameter int MULT_EXC_CODE  = multdiv_sequencer_pkg::MULT_EXC_CODE,
  parameter int DIV_EXC_CODE   = multdiv_sequencer_pkg::DIV_EXC_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_RDY,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        result_exception,
  output logic [31:0] result_status,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  md_state_e        state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic             is_div_q, is_div_d;
  logic [31:0]      res_q, res_d;
  logic             exc_q, exc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    res_d    = res_q;
    exc_d    = exc_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (issue_valid && !flush) begin
          a_d      = issue_a;
          b_d      = issue_b;
          rd_d     = issue_rd;
          is_div_d = issue_is_div;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // Saturating so the counter can never wrap back below the limit.
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        if (md_RDY) begin
          res_d   = md_result;
          exc_d   = md_exception;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush overrides everything, including an md_RDY in the same cycle.
    if (flush) state_d = ST_IDLE;
  end

  // Strobes are suppressed in the same cycle as a flush or reset.
  assign strobe_ok = !flush && !reset;

  always_comb begin
    ctrl_MULT        = (state_q == ST_START) && !is_div_q && strobe_ok;
    ctrl_DIV         = (state_q == ST_START) &&  is_div_q && strobe_ok;
    md_a             = a_q;
    md_b             = b_q;
    stall            = !reset &&
                       (((state_q == ST_IDLE) && issue_valid && !flush) ||
                        (state_q == ST_START) || (state_q == ST_BUSY));
    result_valid     = (state_q == ST_DONE) && strobe_ok;
    result           = result_valid ? res_q : 32'd0;
    result_rd        = result_valid ? rd_q : 5'd0;
    result_exception = result_valid && exc_q;
    result_status    = 32'd0;
    if (result_valid && exc_q)
      result_status = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
    dbg_state        = state_q;
  end

endmodule
